// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared types and default sizes for the posted-write store buffer.
package store_buffer_pkg;

    localparam int SB_DEPTH   = 4;
    localparam int SB_DATA_W  = 32;
    localparam int SB_ADDR_W  = 32;
    localparam int SB_MATCH_W = 8;

    // One buffered store. Field widths follow the package defaults.
    typedef struct packed {
        logic                 valid;
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
    } sb_entry_t;

    // Pointer width for a ring of the given depth (at least one bit).
    function automatic int sb_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/store_buffer_if.sv
// store_buffer_if: CPU load/store port plus memory port of the store buffer.
// master = CPU/memory side, slave = store buffer.
interface store_buffer_if
    import store_buffer_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH,
    parameter int DATA_W = SB_DATA_W,
    parameter int ADDR_W = SB_ADDR_W
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              st_valid;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic              st_ready;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic              memWrite;
    logic              memRead;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writeData;
    logic [DATA_W-1:0] readData;

    modport master (
        output st_valid, st_addr, st_data, ld_valid, ld_addr, readData,
        input  st_ready, ld_data, empty, count, memWrite, memRead, address, writeData
    );

    modport slave (
        input  st_valid, st_addr, st_data, ld_valid, ld_addr, readData,
        output st_ready, ld_data, empty, count, memWrite, memRead, address, writeData
    );

endinterface

// File: rtl/store_buffer_match.sv
// store_buffer_match: youngest-first match of a key against the buffered entries.
// Age is measured backwards from tail; one slot may be excluded (draining head).
module store_buffer_match #(
    parameter int DEPTH   = 4,
    parameter int MATCH_W = 8,
    parameter int DATA_W  = 32,
    parameter int PTR_W   = 2
) (
    input  logic [DEPTH-1:0]   valid,
    input  logic [MATCH_W-1:0] tag  [DEPTH],
    input  logic [DATA_W-1:0]  data [DEPTH],
    input  logic [PTR_W-1:0]   tail,
    input  logic [MATCH_W-1:0] key,
    input  logic               excl_en,
    input  logic [PTR_W-1:0]   excl_idx,
    output logic               hit,
    output logic [PTR_W-1:0]   idx,
    output logic [DATA_W-1:0]  hit_data
);

    // Scan oldest to youngest so the youngest match is the last one written.
    always_comb begin
        hit      = 1'b0;
        idx      = '0;
        hit_data = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (valid[tail - PTR_W'(k)] &&
                tag[tail - PTR_W'(k)] == key &&
                !(excl_en && (tail - PTR_W'(k)) == excl_idx)) begin
                hit      = 1'b1;
                idx      = tail - PTR_W'(k);
                hit_data = data[tail - PTR_W'(k)];
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the load/store port and a single-port memory.
// Loads own the memory port; stores drain in FIFO order in load-free cycles.
// Optional STORE_BUFFER_COALESCE_EN merges a store into a matching non-draining entry.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH   = SB_DEPTH,
    parameter int DATA_W  = SB_DATA_W,
    parameter int ADDR_W  = SB_ADDR_W,
    parameter int MATCH_W = SB_MATCH_W
) (
    input  logic clk,
    input  logic reset,
    store_buffer_if.slave bus
);

    localparam int PTR_W = sb_ptr_w(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    sb_entry_t           ent [DEPTH];
    logic [PTR_W-1:0]    head, tail;
    logic [CNT_W-1:0]    count;

    logic [DEPTH-1:0]     ent_valid;
    logic [MATCH_W-1:0]   ent_tag  [DEPTH];
    logic [SB_DATA_W-1:0] ent_data [DEPTH];

    logic                 full, drain, enq, alloc, upd, coalesce;
    logic [PTR_W-1:0]     st_idx;
    logic                 ld_hit;
    logic [SB_DATA_W-1:0] ld_hit_data;

    // Flatten the entry array into the fields the matchers compare.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_valid[i] = ent[i].valid;
            ent_tag[i]   = ent[i].addr[MATCH_W-1:0];
            ent_data[i]  = ent[i].data;
        end
    end

    store_buffer_match #(
        .DEPTH(DEPTH), .MATCH_W(MATCH_W), .DATA_W(SB_DATA_W), .PTR_W(PTR_W)
    ) u_ld_match (
        .valid(ent_valid), .tag(ent_tag), .data(ent_data), .tail(tail),
        .key(bus.ld_addr[MATCH_W-1:0]), .excl_en(1'b0), .excl_idx(head),
        .hit(ld_hit), .idx(), .hit_data(ld_hit_data)
    );

`ifdef STORE_BUFFER_COALESCE_EN
    store_buffer_match #(
        .DEPTH(DEPTH), .MATCH_W(MATCH_W), .DATA_W(SB_DATA_W), .PTR_W(PTR_W)
    ) u_st_match (
        .valid(ent_valid), .tag(ent_tag), .data(ent_data), .tail(tail),
        .key(bus.st_addr[MATCH_W-1:0]), .excl_en(drain), .excl_idx(head),
        .hit(coalesce), .idx(st_idx), .hit_data()
    );
`else
    assign coalesce = 1'b0;
    assign st_idx   = '0;
`endif

    assign full  = (count == CNT_W'(DEPTH));
    assign drain = !bus.ld_valid && (count != '0);
    assign enq   = bus.st_valid && bus.st_ready;
    assign alloc = enq && !coalesce;
    assign upd   = enq && coalesce;

    assign bus.st_ready = !full || coalesce;
    assign bus.empty    = (count == '0);
    assign bus.count    = count;

    // Memory port arbitration and load result; loads win over draining.
    always_comb begin
        bus.memWrite  = 1'b0;
        bus.memRead   = 1'b0;
        bus.address   = '0;
        bus.writeData = '0;
        bus.ld_data   = '0;
        if (bus.ld_valid) begin
            bus.memRead = 1'b1;
            bus.address = bus.ld_addr;
            bus.ld_data = ld_hit ? DATA_W'(ld_hit_data) : bus.readData;
        end else if (count != '0) begin
            bus.memWrite  = 1'b1;
            bus.address   = ADDR_W'(ent[head].addr);
            bus.writeData = DATA_W'(ent[head].data);
        end
    end

    // Ring pointers, occupancy and entry storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= '0;
            end
        end else begin
            if (drain) begin
                ent[head].valid <= 1'b0;
                head            <= head + PTR_W'(1);
            end
            if (alloc) begin
                ent[tail] <= '{valid: 1'b1,
                               addr:  SB_ADDR_W'(bus.st_addr),
                               data:  SB_DATA_W'(bus.st_data)};
                tail      <= tail + PTR_W'(1);
            end
            if (upd) begin
                ent[st_idx].addr <= SB_ADDR_W'(bus.st_addr);
                ent[st_idx].data <= SB_DATA_W'(bus.st_data);
            end
            count <= count + CNT_W'(alloc) - CNT_W'(drain);
        end
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the datapath's load/store port and the single-port `DataMemory`. Stores are queued and acknowledged at once, then drained to memory in FIFO order in cycles with no load on the port. Loads have priority on the memory port and are forwarded from the youngest matching buffered store. This hides store latency and keeps the memory-side interface unchanged (`memWrite`/`memRead`/`address`/`writeData`/`readData`).

## Interface
- `DEPTH`, 4: number of buffer entries; power of two, at least 2.
- `DATA_W`, 32: store and load data width.
- `ADDR_W`, 32: address width.
- `MATCH_W`, 8: low address bits decoded by memory and compared for forwarding and coalescing. Must equal the memory index width.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `st_valid` in 1: CPU store request.
- `st_addr` in `ADDR_W`: store address.
- `st_data` in `DATA_W`: store data.
- `st_ready` out 1: the buffer can accept a store this cycle.
- `ld_valid` in 1: CPU load request.
- `ld_addr` in `ADDR_W`: load address.
- `ld_data` out `DATA_W`: load result, combinational.
- `empty` out 1: no buffered stores (fence/halt indicator).
- `count` out `$clog2(DEPTH)+1`: occupancy.
- `memWrite` out 1: memory write strobe.
- `memRead` out 1: memory read strobe.
- `address` out `ADDR_W`: memory address.
- `writeData` out `DATA_W`: memory write data.
- `readData` in `DATA_W`: memory read data, combinational from memory.

## Operation
- Circular FIFO with `head`, `tail` and `count` registers.
- **Enqueue:** a store is accepted when `st_valid && st_ready`, and `st_ready = (count != DEPTH)`. Full blocks enqueue even if a drain happens in the same cycle; there is no same-cycle bypass.
- **Port arbitration (combinational):**
  - If `ld_valid`: `memRead=1`, `address=ld_addr`, `memWrite=0`.
  - Else if `count!=0`: `memWrite=1`, `address`/`writeData` = head entry; `head` advances at the edge.
  - Else: all strobes are 0, and `address`/`writeData` are 0.
- **Forwarding:**
  - `ld_data` = data of the youngest valid entry whose `addr[MATCH_W-1:0]` equals `ld_addr[MATCH_W-1:0]`.
  - Otherwise `ld_data = readData`.
  - `ld_data = 0` when `ld_valid=0`.
- **Same-cycle store and load:** the load sees the pre-edge buffer contents. The incoming store is not forwarded.
- **Counter updates:** enqueue and drain in the same cycle leave `count` unchanged, and both pointers advance. Pointers wrap modulo `DEPTH`.
- **Reset (asynchronous):** clears `head`, `tail`, `count` and all entry valid bits. Buffered stores are discarded and never reach memory.
- **Reset values (combinational from the cleared state):** `st_ready=1`, `empty=1`, `count=0`, `memWrite=0`, `memRead=0`, `address=0`, `writeData=0`.

## Timing
- A store accepted at edge N is written to memory at edge N+1 at the earliest (`memWrite` high during cycle N→N+1), provided `ld_valid=0` in that cycle.
- Drain rate is one entry per load-free cycle. A continuous load stream stalls draining indefinitely; no starvation counter is provided.
- Load latency is zero cycles (combinational), for both the forwarded and the memory paths.
- `empty`, `count` and `st_ready` are functions of registered state only.

## Configuration
- `STORE_BUFFER_COALESCE_EN` defined:
  - An accepted store whose `MATCH_W` address bits equal a valid entry overwrites that entry's data and address. No allocation occurs and `count` is unchanged.
  - Exception: if the match is the head entry being drained that cycle, a new entry is allocated instead.
  - A coalescing store is accepted even when full (`st_ready = !full || match`, where `match` excludes a draining head).
- Undefined: every accepted store allocates a new entry.

## Structure
- Package `store_buffer_pkg`:
  - `sb_entry_t` struct {valid, addr, data}.
  - Default `DEPTH`/`MATCH_W` constants.
  - Pointer-width localparam function.
- Sub-module `store_buffer_match`: combinational youngest-first priority matcher over the entry array, relative to `tail`. Outputs hit, index and data. It is instantiated twice under `STORE_BUFFER_COALESCE_EN` (load match and store match), otherwise once.

## Test plan
- Reset mid-drain with 3 entries queued → `count=0`, `empty=1`, `memWrite=0` immediately; no further memory writes.
- Store `addr=0x10,data=0xAA` with loads idle → `memWrite=1`, `address=0x10`, `writeData=0xAA` next cycle; memory word 0x10 = 0xAA; `empty=1` after.
- Stores 0x20←1, 0x20←2, then load 0x20 with `ld_valid` held → `ld_data=2` (youngest); no drain while loading (`memWrite=0`).
- Fill 4 stores while `ld_valid=1` → `st_ready=0`, `count=4`; 5th store not accepted. Release load → four writes in order on consecutive cycles.
- Load 0x130 with entry 0x030 buffered, `MATCH_W=8` → forwarded. Load 0x31 → `readData`.
- With `STORE_BUFFER_COALESCE_EN`: full buffer, store to a matching non-head address → accepted, `count` stays 4, and the later drain writes the new data once.
